// File: rtl/pos_check_pkg.sv
// Shared types and constants for the PoS truth-table checker.
// Holds the sweep FSM state encoding, point count and canonical masks.
// Pure declarations; no logic.
package pos_check_pkg;

  localparam int DEF_NUM_FUNCS = 5;
  localparam int DEF_NUM_VARS  = 4;
  localparam int DEF_ERR_W     = 8;
  localparam int NUM_POINTS    = 2 ** DEF_NUM_VARS;

  // Expected truth tables, bit i = function value at {x,y,w,z} = i.
  localparam logic [15:0] MASK_C = 16'hD698;
  localparam logic [15:0] MASK_D = 16'hBCA9;
  localparam logic [15:0] MASK_E = 16'hF3D0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pos_index_counter.sv
// Sweep index counter with synchronous clear, increment enable and terminal flag.
// Latency: count updates one cycle after clr/inc; tc is combinational from the count.
// No backpressure; clr has priority over inc.
module pos_index_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/pos_truth_table_checker.sv
// Clocked truth-table sweep of the PoS function outputs against a latched mask.
// Latency: done pulses 33 cycles after start acceptance (two cycles per point + 1).
// No backpressure; start is only honoured in IDLE and is otherwise dropped.
module pos_truth_table_checker
  import pos_check_pkg::*;
#(
  parameter int NUM_FUNCS = DEF_NUM_FUNCS,
  parameter int NUM_VARS  = DEF_NUM_VARS,
  parameter int ERR_W     = DEF_ERR_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_FUNCS*(2**NUM_VARS)-1:0]  exp_mask,
  input  logic [NUM_FUNCS-1:0]                func_in,
  output logic [NUM_VARS-1:0]                 vars,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [ERR_W-1:0]                    err_count,
  output logic [NUM_FUNCS-1:0]                fail_mask,
  output logic [NUM_VARS-1:0]                 first_fail_idx,
  output logic [NUM_FUNCS-1:0]                first_fail_func
);

  localparam int N_PTS  = 2 ** NUM_VARS;
  localparam int MASK_W = NUM_FUNCS * N_PTS;

  // Every function can mismatch at every point; the counter must hold that.
  if (ERR_W < $clog2(MASK_W + 1)) begin : g_err_w_check
    $error("ERR_W too narrow for NUM_FUNCS * 2**NUM_VARS mismatches");
  end

  state_t               state_q, state_d;
  logic [MASK_W-1:0]    exp_q, exp_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [NUM_FUNCS-1:0] fail_q, fail_d;
  logic [NUM_VARS-1:0]  ffi_q, ffi_d;
  logic [NUM_FUNCS-1:0] fff_q, fff_d;
  logic                 pass_q, pass_d;

  logic                 cnt_clr;
  logic                 cnt_inc;
  logic [NUM_VARS-1:0]  idx;
  logic                 idx_tc;
  logic [NUM_FUNCS-1:0] mism;
  logic [ERR_W-1:0]     mism_cnt;

  pos_index_counter #(
    .W (NUM_VARS)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (idx),
    .tc    (idx_tc)
  );

  // Per-function mismatch at the current point and how many functions missed.
  always_comb begin
    mism     = '0;
    mism_cnt = '0;
    for (int f = 0; f < NUM_FUNCS; f++) begin
      mism[f]  = func_in[f] ^ exp_q[f*N_PTS + int'(idx)];
      mism_cnt = mism_cnt + ERR_W'(mism[f]);
    end
  end

  // Sweep sequencing and result accumulation.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = err_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    fff_d   = fff_q;
    pass_d  = pass_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = exp_mask;
          err_d   = '0;
          fail_d  = '0;
          ffi_d   = '0;
          fff_d   = '0;
          pass_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        err_d  = err_q + mism_cnt;
        fail_d = fail_q | mism;
        // No mismatch recorded so far means this is the first failing point.
        if ((mism != '0) && (err_q == '0)) begin
          ffi_d = idx;
          fff_d = mism;
        end
        if (idx_tc) begin
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      exp_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      fff_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      fff_q   <= fff_d;
      pass_q  <= pass_d;
    end
  end

  assign vars            = idx;
  assign busy            = (state_q == DRIVE) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign fail_mask       = fail_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_func = fff_q;

endmodule

// File: tb/tb_pos_truth_table_checker.sv
// Bench for the PoS truth-table checker: modelled PoS outputs with injectable faults,
// a queue of expected sweep results popped by a monitor on each done pulse,
// and per-cycle checks of the sweep timing.
module tb_pos_truth_table_checker;
  import pos_check_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] exp_mask;
  logic [4:0]  func_in;
  logic [3:0]  vars;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [4:0]  fail_mask;
  logic [3:0]  first_fail_idx;
  logic [4:0]  first_fail_func;

  pos_truth_table_checker dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .exp_mask        (exp_mask),
    .func_in         (func_in),
    .vars            (vars),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .fail_mask       (fail_mask),
    .first_fail_idx  (first_fail_idx),
    .first_fail_func (first_fail_func)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [4:0] fm;
    logic [3:0] ffi;
    logic [4:0] fff;
  } res_t;

  res_t exp_results[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Upstream PoS truth tables (A,B random, C..E canonical) and fault injection.
  logic [15:0] g0, g1, g2, g3, g4;
  logic [4:0]  fault_func;
  int          fault_idx;
  bit          tie0;

  assign func_in = tie0 ? 5'b0 :
                   ({g4[vars], g3[vars], g2[vars], g1[vars], g0[vars]} ^
                    ((int'(vars) == fault_idx) ? fault_func : 5'b0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: walk all 16 points, compare what the upstream block produces
  // with the mask, tally mismatches and note the first failing point.
  function automatic res_t model(input logic [79:0] em);
    res_t       r;
    logic [4:0] act;
    logic [4:0] d;
    logic [15:0] g [5];
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3; g[4] = g4;
    r.err = 0; r.fm = 0; r.ffi = 0; r.fff = 0;
    for (int i = 0; i < 16; i++) begin
      for (int f = 0; f < 5; f++) act[f] = tie0 ? 1'b0 : g[f][i];
      if (!tie0 && i == fault_idx) act = act ^ fault_func;
      for (int f = 0; f < 5; f++) d[f] = act[f] ^ em[f*16 + i];
      if (d != 0 && r.err == 0) begin
        r.ffi = 4'(i);
        r.fff = d;
      end
      r.err = r.err + 8'($countones(d));
      r.fm  = r.fm | d;
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_results.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none at %0t", $time);
      end else begin
        res_t r;
        r = exp_results.pop_front();
        check("pass",            32'(pass),            32'(r.pass));
        check("err_count",       32'(err_count),       32'(r.err));
        check("fail_mask",       32'(fail_mask),       32'(r.fm));
        check("first_fail_idx",  32'(first_fail_idx),  32'(r.ffi));
        check("first_fail_func", 32'(first_fail_func), 32'(r.fff));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_vars"}, 32'(vars), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"},  32'(err_count), 0);
    check({tag, "_fm"},   32'(fail_mask), 0);
    check({tag, "_ffi"},  32'(first_fail_idx), 0);
    check({tag, "_fff"},  32'(first_fail_func), 0);
  endtask

  // One sweep. abort_at >= 0 asserts reset at that cycle offset instead of
  // finishing; pokes re-pulses start at offsets 3 and 10; mask_chg_at
  // scrambles exp_mask at that offset. Offset 0 is the cycle after acceptance.
  task automatic run_sweep(input logic [79:0] em, input int abort_at,
                           input bit pokes, input int mask_chg_at);
    res_t r;
    r = model(em);
    exp_mask = em;
    if (abort_at < 0) exp_results.push_back(r);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= 33; c++) begin
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge clk) reset = 1'b0;
        return;
      end
      check("vars_seq", 32'(vars), (c < 32) ? 32'(c / 2) : 32'd15);
      check("done_time", 32'(done), (c == 32) ? 32'd1 : 32'd0);
      if (c <= 32) check("busy_time", 32'(busy), (c < 32) ? 32'd1 : 32'd0);
      if (pokes) start = (c == 3 || c == 10);
      if (c == mask_chg_at) exp_mask = ~em;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_err",  32'(err_count), 32'(r.err));
    check("hold_pass", 32'(pass),      32'(r.pass));
  endtask

  initial begin
    logic [79:0] golden;
    logic [79:0] em;
    reset      = 1'b1;
    start      = 1'b0;
    exp_mask   = '0;
    tie0       = 1'b0;
    fault_idx  = -1;
    fault_func = '0;
    g0 = 16'($urandom);
    g1 = 16'($urandom);
    g2 = MASK_C;
    g3 = MASK_D;
    g4 = MASK_E;
    golden = {g4, g3, g2, g1, g0};

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Correct masks: clean pass.
    run_sweep(golden, -1, 1'b0, -1);

    // Single inverted output on function 2 at point 5.
    fault_idx = 5; fault_func = 5'b00100;
    run_sweep(golden, -1, 1'b0, -1);
    fault_idx = -1; fault_func = '0;

    // Outputs stuck low against an all-ones mask: every point fails.
    tie0 = 1'b1;
    run_sweep({80{1'b1}}, -1, 1'b0, -1);
    tie0 = 1'b0;

    // Start re-pulsed while running must not restart or queue a sweep.
    run_sweep(golden, -1, 1'b1, -1);

    // Reset mid-sweep, then a full clean sweep.
    run_sweep(golden, 12, 1'b0, -1);
    run_sweep(golden, -1, 1'b0, -1);

    // Mask changed after acceptance must not affect results.
    run_sweep(golden, -1, 1'b0, 4);

    // Random masks and random faults.
    for (int t = 0; t < 10; t++) begin
      em = golden;
      for (int b = 0; b < 80; b++) begin
        if ($urandom_range(0, 15) == 0) em[b] = ~em[b];
      end
      fault_idx  = int'($urandom_range(0, 16));
      fault_func = 5'($urandom);
      run_sweep(em, -1, 1'b0, -1);
    end
    fault_idx = -1;

    repeat (2) @(negedge clk);
    check("results_drained", 32'(exp_results.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pos_truth_table_checker.md
Name: pos_truth_table_checker

Overview:
Sequential self-checker that sits directly downstream of, and wraps, the combinational PoS function blocks. On request it sweeps every input combination {x,y,w,z}, drives it to the PoS stage, and samples the PoS outputs one cycle later. Each output is compared against an expected truth-table mask, and the block reports a per-function pass/fail, an error count and the first failing point. It replaces the manual #1-delay monitor sweep with a clocked, repeatable checker.

Parameters:
NUM_FUNCS, 5, number of PoS outputs checked (pA..pE)
NUM_VARS, 4, number of input variables swept; 2**NUM_VARS points
ERR_W, 8, width of the error counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
exp_mask  input  NUM_FUNCS*2**NUM_VARS  expected outputs; bit [f*16+i] is the expected value of function f at index i
func_in  input  NUM_FUNCS  PoS outputs from the upstream block, bit f = function f
vars  output  NUM_VARS  driven {x,y,w,z}, x = MSB; index i drives vars=i
busy  output  1  high from start acceptance until done
done  output  1  single-cycle pulse at sweep end
pass  output  1  1 iff last completed sweep had zero mismatches
err_count  output  ERR_W  total mismatches in current/last sweep
fail_mask  output  NUM_FUNCS  sticky; bit f set if function f mismatched anywhere
first_fail_idx  output  NUM_VARS  index of first mismatch; valid when pass=0
first_fail_func  output  NUM_FUNCS  functions mismatching at first_fail_idx

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, vars=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, first_fail_idx=0, first_fail_func=0.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 at an edge accepts the request.
  - On acceptance: latch exp_mask, and clear idx, err_count, fail_mask, first_fail_* and pass.
  - Next state DRIVE; busy=1.
- DRIVE: vars=idx for one full cycle so the combinational PoS logic settles. Next state CHECK.
- CHECK: vars is held.
  - At the edge, compute mism = func_in XOR {latched exp_mask bit [f*16+idx] for each f}.
  - err_count += popcount(mism); fail_mask |= mism.
  - If mism≠0 and no earlier mismatch, capture first_fail_idx=idx and first_fail_func=mism.
  - If idx == 2**NUM_VARS-1: go to DONE. Otherwise idx++ and go to DRIVE.
- DONE: done=1 and busy=0 for exactly one cycle; pass = (err_count==0). Next state IDLE.
- Latency: start accepted at edge k. CHECK for index i happens at edge k+2i+2. done is high in the cycle after edge k+32, i.e. 33 cycles after acceptance.
- Results hold their values in IDLE until the next start is accepted.
- start while busy or in DONE: ignored, no queueing.
- Changes to exp_mask mid-sweep have no effect, because the value is latched at acceptance.
- idx never wraps: the terminal compare exits to DONE.
- err_count width rule: maximum is NUM_FUNCS*2**NUM_VARS = 80, which fits in ERR_W=8. No saturation logic is required; implementations assert ERR_W is sufficient at elaboration.
- Reset mid-sweep: abort immediately to the reset values; no done pulse.
- X on func_in is not filtered. It is treated as a mismatch only where XOR resolves to 1.

Decomposition:
- Shared package pos_check_pkg holds:
  - state enum (IDLE, DRIVE, CHECK, DONE)
  - NUM_POINTS = 2**NUM_VARS
  - canonical expected masks: MASK_C=16'hD698, MASK_D=16'hBCA9, MASK_E=16'hF3D0
- One natural sub-module, pos_index_counter: a NUM_VARS-bit counter with clear, increment enable and a terminal-count flag.
- popcount and compare logic stay inline.

Test Plan:
- Golden PoS blocks with exp_mask set to the correct masks (C=16'hD698 for ΠM(0,1,2,5,6,8,11,13), D=16'hBCA9, E=16'hF3D0), pulse start → done 33 cycles later, pass=1, err_count=0, fail_mask=0.
- Force func_in[2] inverted at index 5 only → pass=0, err_count=1, fail_mask=5'b00100, first_fail_idx=5, first_fail_func=5'b00100.
- Tie func_in=0 with all exp_mask bits=1 → err_count=80, fail_mask=5'b11111, first_fail_idx=0, first_fail_func=5'b11111.
- Pulse start at cycles 3 and 10 of a running sweep → ignored; single done at cycle 33; vars sequence 0..15, each value held for 2 cycles.
- Assert reset at cycle 12 of a sweep → all outputs return to reset values within the same cycle, no done pulse; a new start then runs a full, clean sweep.
- Change exp_mask at cycle 4 of a sweep → results match the mask latched at start.
